rapcla_pipe_adder: RTL and testbench



---
 rtl/rapcla_pipe_adder_pkg.sv | 49 ++++
 rtl/rapcla_pipe_adder_gc.sv | 23 ++
 rtl/rapcla_pipe_adder.sv | 150 +++++++++++++++
 tb/tb_rapcla_pipe_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rapcla_pipe_adder_pkg.sv
// Shared constants and golden model for the approximate carry-lookahead adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rapcla_pipe_adder_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int BLK_DEF   = 4;

    // Number of lookahead blocks for a given operand width and block size.
    function automatic int nblk(input int width, input int blk);
        return width / blk;
    endfunction

    // Plain add of one block with an explicit carry-in; result is {carry_out, block_sum}.
    function automatic logic [BLK_DEF:0] blk_add(input logic [WIDTH_DEF-1:0] a,
                                                 input logic [WIDTH_DEF-1:0] b,
                                                 input int                   j,
                                                 input logic                 c);
        return {1'b0, a[j*BLK_DEF +: BLK_DEF]} + {1'b0, b[j*BLK_DEF +: BLK_DEF]}
             + {{BLK_DEF{1'b0}}, c};
    endfunction

    // Approximate sum {cout, sum}: each block sees only the carry generated by its
    // immediate lower neighbour assuming that neighbour had no carry-in, except that
    // block 1 also sees block 0's propagated carry-in.
    function automatic logic [WIDTH_DEF:0] approx_add_ref(input logic [WIDTH_DEF-1:0] a,
                                                          input logic [WIDTH_DEF-1:0] b,
                                                          input logic                 cin);
        logic [WIDTH_DEF-1:0] s;
        logic [BLK_DEF:0]     part;
        logic                 c_in;
        logic                 c_out;
        s     = '0;
        c_out = 1'b0;
        for (int j = 0; j < WIDTH_DEF / BLK_DEF; j++) begin
            if (j == 0) begin
                c_in = cin;
            end else begin
                part = blk_add(a, b, j - 1, (j == 1) ? cin : 1'b0);
                c_in = part[BLK_DEF];
            end
            part                      = blk_add(a, b, j, c_in);
            s[j*BLK_DEF +: BLK_DEF]   = part[BLK_DEF-1:0];
            c_out                     = part[BLK_DEF];
        end
        return {c_out, s};
    endfunction

endpackage

// File: rtl/rapcla_pipe_adder_gc.sv
// Valency-parameterised gray cell: group generate over VALENCY bit-level g/p pairs.
// Latency: combinational.
// Backpressure: none (pure logic).
module rapcla_pipe_adder_gc #(
    parameter int VALENCY = 4
) (
    input  logic [VALENCY-1:0] i_g,
    input  logic [VALENCY-1:0] i_p,
    output logic               o_gg
);

    logic w_acc;

    // Prefix recurrence from LSB upward: G = g[k] | p[k] & G_below.
    always_comb begin
        w_acc = 1'b0;
        for (int k = 0; k < VALENCY; k++) begin
            w_acc = i_g[k] | (i_p[k] & w_acc);
        end
        o_gg = w_acc;
    end

endmodule

// File: rtl/rapcla_pipe_adder.sv
// Three-stage approximate carry-lookahead adder: bit g/p, block carries, sum/cout.
// Latency: 3 cycles input transfer to out_valid; one beat per cycle when unstalled.
// Backpressure: valid/ready per stage; up to 3 beats held, in_ready combinational from out_ready.
module rapcla_pipe_adder
    import rapcla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLK   = BLK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = nblk(WIDTH, BLK);

    // Stage 1: bit-level generate/propagate
    logic             r_v1;
    logic [WIDTH-1:0] r_g1;
    logic [WIDTH-1:0] r_p1;
    logic             r_cin1;

    // Stage 2: block carries; only the in-block g bits below each block MSB are needed later
    logic                       r_v2;
    logic [WIDTH-1:0]           r_p2;
    logic [NBLK-1:0][BLK-2:0]   r_g2;
    logic [NBLK-1:0]            r_cblk2;
    logic                       r_gg_last2;
    logic                       r_pp_last2;

    // Stage 3: result
    logic             r_v3;
    logic [WIDTH-1:0] r_sum3;
    logic             r_cout3;

    logic             w_open2;
    logic             w_open3;
    logic [NBLK-1:0]  w_gg;
    logic             w_pp0;
    logic             w_pp_last;
    logic [NBLK-1:0]  w_cblk;
    logic [WIDTH-1:0] w_sum3;
    logic             w_cout3;
    logic             w_c;

    // A stage can take new data when it is empty or its contents move on this cycle.
    assign w_open3   = ~r_v3 | out_ready;
    assign w_open2   = ~r_v2 | (r_v2 & w_open3);
    assign in_ready  = ~r_v1 | w_open2;

    assign out_valid = r_v3;
    assign sum       = r_sum3;
    assign cout      = r_cout3;

    // Group generate per block from the gray cells; group propagate is a plain AND.
    for (genvar j = 0; j < NBLK; j++) begin : g_gc
        rapcla_pipe_adder_gc #(.VALENCY(BLK)) u_gc (
            .i_g  (r_g1[j*BLK +: BLK]),
            .i_p  (r_p1[j*BLK +: BLK]),
            .o_gg (w_gg[j])
        );
    end

    assign w_pp0     = &r_p1[BLK-1:0];
    assign w_pp_last = &r_p1[WIDTH-1 -: BLK];

    // Speculative block carries: block 1 still sees cin through block 0, higher blocks
    // see only their neighbour's own generate.
    always_comb begin
        w_cblk    = '0;
        w_cblk[0] = r_cin1;
        w_cblk[1] = w_gg[0] | (w_pp0 & r_cin1);
        for (int j = 2; j < NBLK; j++) begin
            w_cblk[j] = w_gg[j-1];
        end
    end

    // Exact ripple inside each block, seeded from that block's speculative carry.
    always_comb begin
        w_sum3 = '0;
        w_c    = 1'b0;
        for (int j = 0; j < NBLK; j++) begin
            w_c             = r_cblk2[j];
            w_sum3[j*BLK]   = r_p2[j*BLK] ^ w_c;
            for (int k = 1; k < BLK; k++) begin
                w_c               = r_g2[j][k-1] | (r_p2[j*BLK+k-1] & w_c);
                w_sum3[j*BLK+k]   = r_p2[j*BLK+k] ^ w_c;
            end
        end
        w_cout3 = r_gg_last2 | (r_pp_last2 & r_cblk2[NBLK-1]);
    end

    // Stage 1 register: capture operands as g/p whenever the stage is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_g1   <= '0;
            r_p1   <= '0;
            r_cin1 <= 1'b0;
        end else if (in_ready) begin
            r_v1   <= in_valid;
            r_g1   <= a & b;
            r_p1   <= a ^ b;
            r_cin1 <= cin;
        end
    end

    // Stage 2 register: block carries plus the bits stage 3 still needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2       <= 1'b0;
            r_p2       <= '0;
            r_g2       <= '0;
            r_cblk2    <= '0;
            r_gg_last2 <= 1'b0;
            r_pp_last2 <= 1'b0;
        end else if (w_open2) begin
            r_v2       <= r_v1;
            r_p2       <= r_p1;
            for (int j = 0; j < NBLK; j++) begin
                r_g2[j] <= r_g1[j*BLK +: BLK-1];
            end
            r_cblk2    <= w_cblk;
            r_gg_last2 <= w_gg[NBLK-1];
            r_pp_last2 <= w_pp_last;
        end
    end

    // Stage 3 register: result holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_sum3  <= '0;
            r_cout3 <= 1'b0;
        end else if (w_open3) begin
            r_v3    <= r_v2;
            r_sum3  <= w_sum3;
            r_cout3 <= w_cout3;
        end
    end

endmodule

// File: tb/tb_rapcla_pipe_adder.sv
// Directed and random bench for the approximate carry-lookahead pipeline.
// Latency: checks 3-cycle latency and stall/flush behaviour.
// Backpressure: drives out_ready low/high/random.
module tb_rapcla_pipe_adder;
    import rapcla_pipe_adder_pkg::*;

    localparam int W = WIDTH_DEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] bp_a [4] = '{16'h1234, 16'h8000, 16'h0F00, 16'h0FF0};
    logic [W-1:0] bp_b [4] = '{16'h1111, 16'h8000, 16'h0100, 16'h0010};
    logic         bp_ci[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] bp_s [4] = '{16'h2345, 16'h0001, 16'h1000, 16'h0000};
    logic         bp_co[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic [W:0]   q[$];
    logic [W:0]   exp_v;
    int           n_sent;
    int           n_rcv;
    logic         pending;

    always #5 clk = ~clk;

    rapcla_pipe_adder #(.WIDTH(W), .BLK(BLK_DEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        cin      = tc;
    endtask

    task automatic send_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic [W-1:0] es, input logic ec);
        @(negedge clk);
        drive(ta, tb_, tc);
        #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_lat3"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        pending   = 1'b0;
        n_sent    = 0;
        n_rcv     = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single beats with latency
        send_one("v3p5",   16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0);
        send_one("vff1",   16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0);
        send_one("vcin",   16'h0000, 16'h000F, 1'b1, 16'h0010, 1'b0);
        send_one("vffff",  16'hFFFF, 16'h0001, 1'b0, 16'hFF00, 1'b0);
        send_one("vtop",   16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

        // Back-pressure: fill three stages, fourth beat blocked
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            drive(bp_a[k], bp_b[k], bp_ci[k]);
            #1;
            chk($sformatf("bp_rdy%0d", k), 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        chk("bp_full_sum", 32'(sum), 32'(bp_s[0]));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_hold_rdy%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp_hold_sum%0d", k), 32'(sum), 32'(bp_s[0]));
            chk($sformatf("bp_hold_cout%0d", k), 32'(cout), 32'(bp_co[0]));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        chk("bp_release_sum", 32'(sum), 32'(bp_s[0]));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("bp_drain_valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_drain_sum%0d", k), 32'(sum), 32'(bp_s[k]));
            chk($sformatf("bp_drain_cout%0d", k), 32'(cout), 32'(bp_co[k]));
        end
        @(negedge clk);
        #1;
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        drive(16'h0003, 16'h0005, 1'b0);
        @(negedge clk);
        drive(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        chk("mid_pre_sum", 32'(sum), 32'h0008);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_idle%0d", k), 32'(out_valid), 32'd0);
        end
        send_one("post_rst", 16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0);

        // Random back-to-back traffic with random consumer stalls
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20000 && n_rcv < 1000; cyc++) begin
            @(negedge clk);
            if (!pending) begin
                if (n_sent < 1000) begin
                    drive(W'($urandom), W'($urandom), 1'($urandom));
                    pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_extra_beat", 32'(q.size()), 32'd1);
                end else begin
                    exp_v = q.pop_front();
                    chk($sformatf("rand%0d", n_rcv), 32'({cout, sum}), 32'(exp_v));
                end
                n_rcv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(approx_add_ref(a, b, cin));
                n_sent++;
                pending = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_received", 32'(n_rcv), 32'd1000);
        chk("rand_queue_empty", 32'(q.size()), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("rand_no_dup", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
